alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, ring duration in clk_sec ticks (range 1..255).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze duration in clk_sec ticks (range 1..1023).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_p  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port time_now  input  16  current time, BCD {hr10,hr1,min10,min1}.
REQ-006 SHALL have port clk_sec  input  1  one-cycle pulse per second.
REQ-007 SHALL have ports btn_mode_pe, btn_hr_pe, btn_min_pe, btn_stop_pe  input  1 each  debounced one-cycle button edge pulses.
REQ-008 SHALL have port alarm_value  output  16  stored alarm time, BCD {hr10,hr1,min10,min1}.
REQ-009 SHALL have ports set_mode, armed, ringing  output  1 each  state indicators for LEDs.
REQ-010 SHALL have port buzz  output  1  buzzer drive.

Function
REQ-011 SHALL implement FSM states IDLE, SET, ARMED, RINGING, and SNOOZE (SNOOZE only per REQ-030).
REQ-012 SHALL transition on btn_mode_pe: IDLE->SET, SET->ARMED, ARMED->IDLE; btn_mode_pe SHALL be ignored in RINGING and SNOOZE.
REQ-013 In SET, btn_hr_pe SHALL increment the alarm hour in BCD 00..23, wrapping 23->00; minutes unaffected.
REQ-014 In SET, btn_min_pe SHALL increment the alarm minute in BCD 00..59, wrapping 59->00 without carry into hour.
REQ-015 Simultaneous btn_hr_pe and btn_min_pe in SET SHALL both apply in the same cycle; outside SET, alarm_value SHALL hold.
REQ-016 SHALL register time_now every cycle as time_prev; match_edge = (time_now == alarm_value) && (time_prev != alarm_value).
REQ-017 In ARMED, match_edge SHALL move the FSM to RINGING on the same edge; ringing=1 from the next cycle (1-cycle latency).
REQ-018 Entering SET or ARMED while time_now already equals alarm_value SHALL NOT ring until the next match edge.
REQ-019 In RINGING, buzz SHALL be 1 on entry and toggle on each clk_sec; ring_cnt SHALL count clk_sec ticks from 0.
REQ-020 When ring_cnt reaches RING_SEC-1 and clk_sec is high, SHALL return to ARMED with buzz=0.
REQ-021 btn_stop_pe in RINGING (or SNOOZE) SHALL return to ARMED next edge, buzz=0, counters cleared; stop SHALL win over any same-cycle button.
REQ-022 ARMED with same-cycle btn_mode_pe and match_edge SHALL go to IDLE (disarm wins).
REQ-023 Outputs: set_mode=(state==SET); armed=(state in ARMED, RINGING, SNOOZE); ringing=(state==RINGING); buzz=0 outside RINGING.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset_p SHALL asynchronously force state=IDLE, alarm_value=16'h0700, time_prev=16'h0000, buzz=0, ring_cnt=0, snooze_cnt=0.
REQ-026 Reset during RINGING or SNOOZE SHALL drop buzz and ringing immediately, without waiting for a clock edge.
REQ-027 After reset release, no alarm SHALL fire until the FSM passes SET->ARMED.

Configuration
REQ-028 SHALL support macro ALARM_SNOOZE_EN.
REQ-029 Without ALARM_SNOOZE_EN: SNOOZE state and snooze_cnt SHALL be absent; btn_hr_pe in RINGING SHALL be ignored.
REQ-030 With ALARM_SNOOZE_EN: btn_hr_pe in RINGING SHALL move to SNOOZE (buzz=0, ring_cnt=0); snooze_cnt counts clk_sec; at SNOOZE_SEC-1 with clk_sec -> RINGING; btn_stop_pe in SNOOZE -> ARMED.

Structure
REQ-031 Package alarm_pkg SHALL hold the state encoding, the reset alarm constant 16'h0700, and BCD limits (23, 59).
REQ-032 SHALL instantiate sub-module bcd_wrap_counter (two-digit BCD counter, parameter MAX, inc pulse input) twice, for hour and minute.

Verification
REQ-033 Reset; btn_mode x1; btn_hr x17; btn_min x61 -> alarm_value=16'h0001 after wrap (hr 07+17=24 -> 00, min 61 -> 01), set_mode=1.
REQ-034 ARMED with alarm 16'h0730; time_now 0729->0730 -> ringing=1 one cycle later, buzz toggles per clk_sec; RING_SEC=4 -> ARMED after 4 ticks.
REQ-035 RINGING; btn_stop_pe with btn_hr_pe same cycle -> ARMED, buzz=0; time_now held at 0730 -> no re-ring.
REQ-036 ARMED with btn_mode_pe coincident with match_edge -> IDLE, ringing stays 0.
REQ-037 ALARM_SNOOZE_EN, SNOOZE_SEC=3: btn_hr_pe in RINGING -> buzz=0; after 3 clk_sec -> ringing=1 again.
REQ-038 Assert reset_p mid-RINGING between clock edges -> buzz=0 immediately, alarm_value=16'h0700.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM encoding, reset alarm time, BCD limits.
// The SNOOZE state exists only when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RINGING = 3'd3
`ifdef ALARM_SNOOZE_EN
    ,
    ST_SNOOZE  = 3'd4
`endif
  } state_e;

  localparam logic [15:0] ALARM_RST_VAL = 16'h0700;
  localparam int          HOUR_MAX      = 23;
  localparam int          MIN_MAX       = 59;

  // Binary 0..99 to packed two-digit BCD {tens, ones}.
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter, 00..MAX, advancing by one on each i_inc pulse and wrapping MAX -> 00.
// No carry output: hour and minute fields are set independently.
module bcd_wrap_counter
  import alarm_pkg::*;
#(
  parameter int         MAX     = 59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  output logic [7:0] o_value
);

  localparam logic [7:0] MAX_BCD = to_bcd8(MAX);

  logic [7:0] r_value;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_value;
    if (i_inc) begin
      if (r_value == MAX_BCD) begin
        w_next = 8'h00;
      end else if (r_value[3:0] == 4'd9) begin
        w_next = {r_value[7:4] + 4'd1, 4'd0};
      end else begin
        w_next = {r_value[7:4], r_value[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= RST_VAL;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time setting, arm/disarm, edge-triggered ringing with buzzer toggle.
// Optional snooze (btn_hr in RINGING) is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [15:0] time_now,
  input  logic        clk_sec,
  input  logic        btn_mode_pe,
  input  logic        btn_hr_pe,
  input  logic        btn_min_pe,
  input  logic        btn_stop_pe,
  output logic [15:0] alarm_value,
  output logic        set_mode,
  output logic        armed,
  output logic        ringing,
  output logic        buzz,
  output logic [2:0]  dbg_state
);

  if (RING_SEC < 1 || RING_SEC > 255) begin : g_ring_sec_range
    $error("RING_SEC must be in 1..255");
  end
  if (SNOOZE_SEC < 1 || SNOOZE_SEC > 1023) begin : g_snooze_sec_range
    $error("SNOOZE_SEC must be in 1..1023");
  end

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  state_e      r_state;
  state_e      w_state_n;
  logic [15:0] r_time_prev;
  logic        w_match_edge;
  logic [7:0]  r_ring_cnt;
  logic [7:0]  w_ring_cnt_n;
  logic        r_set_mode;
  logic        r_armed;
  logic        r_ringing;
  logic        r_buzz;
  logic        w_buzz_n;
  logic        w_armed_n;
  logic [7:0]  w_hr;
  logic [7:0]  w_min;
  logic        w_hr_inc;
  logic        w_min_inc;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
  logic [9:0] r_snooze_cnt;
  logic [9:0] w_snooze_cnt_n;
`endif

  // Alarm fields only move while the user is in SET.
  assign w_hr_inc  = (r_state == ST_SET) && btn_hr_pe;
  assign w_min_inc = (r_state == ST_SET) && btn_min_pe;

  bcd_wrap_counter #(
    .MAX     (HOUR_MAX),
    .RST_VAL (ALARM_RST_VAL[15:8])
  ) u_hour (
    .clk     (clk),
    .rst     (reset_p),
    .i_inc   (w_hr_inc),
    .o_value (w_hr)
  );

  bcd_wrap_counter #(
    .MAX     (MIN_MAX),
    .RST_VAL (ALARM_RST_VAL[7:0])
  ) u_min (
    .clk     (clk),
    .rst     (reset_p),
    .i_inc   (w_min_inc),
    .o_value (w_min)
  );

  assign alarm_value = {w_hr, w_min};

  // Ring only on the cycle time_now first becomes equal, never on a standing match.
  assign w_match_edge = (time_now == alarm_value) && (r_time_prev != alarm_value);

  always_comb begin
    w_state_n    = r_state;
    w_ring_cnt_n = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_snooze_cnt_n = r_snooze_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (btn_mode_pe) w_state_n = ST_SET;
      end
      ST_SET: begin
        if (btn_mode_pe) w_state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (btn_mode_pe) begin
          w_state_n = ST_IDLE;
        end else if (w_match_edge) begin
          w_state_n    = ST_RINGING;
          w_ring_cnt_n = 8'd0;
        end
      end
      ST_RINGING: begin
        if (btn_stop_pe) begin
          w_state_n    = ST_ARMED;
          w_ring_cnt_n = 8'd0;
`ifdef ALARM_SNOOZE_EN
        end else if (btn_hr_pe) begin
          w_state_n      = ST_SNOOZE;
          w_ring_cnt_n   = 8'd0;
          w_snooze_cnt_n = 10'd0;
`endif
        end else if (clk_sec) begin
          if (r_ring_cnt == RING_LAST) begin
            w_state_n    = ST_ARMED;
            w_ring_cnt_n = 8'd0;
          end else begin
            w_ring_cnt_n = r_ring_cnt + 8'd1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (btn_stop_pe) begin
          w_state_n      = ST_ARMED;
          w_snooze_cnt_n = 10'd0;
        end else if (clk_sec) begin
          if (r_snooze_cnt == SNOOZE_LAST) begin
            w_state_n      = ST_RINGING;
            w_snooze_cnt_n = 10'd0;
            w_ring_cnt_n   = 8'd0;
          end else begin
            w_snooze_cnt_n = r_snooze_cnt + 10'd1;
          end
        end
      end
`endif
      default: begin
        w_state_n    = ST_IDLE;
        w_ring_cnt_n = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_comb begin
    w_buzz_n = 1'b0;
    if (w_state_n == ST_RINGING) begin
      if (r_state != ST_RINGING) begin
        w_buzz_n = 1'b1;
      end else begin
        w_buzz_n = clk_sec ? ~r_buzz : r_buzz;
      end
    end
    w_armed_n = (w_state_n == ST_ARMED) || (w_state_n == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
    if (w_state_n == ST_SNOOZE) w_armed_n = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= ST_IDLE;
      r_time_prev <= 16'h0000;
      r_ring_cnt  <= 8'd0;
      r_set_mode  <= 1'b0;
      r_armed     <= 1'b0;
      r_ringing   <= 1'b0;
      r_buzz      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_time_prev <= time_now;
      r_ring_cnt  <= w_ring_cnt_n;
      r_set_mode  <= (w_state_n == ST_SET);
      r_armed     <= w_armed_n;
      r_ringing   <= (w_state_n == ST_RINGING);
      r_buzz      <= w_buzz_n;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_snooze_cnt <= 10'd0;
    end else begin
      r_snooze_cnt <= w_snooze_cnt_n;
    end
  end
`endif

  assign set_mode  = r_set_mode;
  assign armed     = r_armed;
  assign ringing   = r_ringing;
  assign buzz      = r_buzz;
  assign dbg_state = r_state;

endmodule
